int_req_ctrl: RTL and testbench

- Interrupt request controller that sits directly upstream of the processor's `int_flag`/`ack` interrupt port.
- Edge-detects up to NUM_SRC external interrupt lines, latches them as pending and applies a mask.
- Arbitrates among pending, unmasked sources and holds `int_flag` until the core acknowledges.
- Presents the granted source's handler vector on a 16-bit bus that the core reads through its input port.
- Enforces a hold-off gap between interrupts and recovers from a missing acknowledge.

---
 rtl/int_req_ctrl_pkg.sv | 22 ++
 rtl/int_prio_arb.sv | 47 ++++
 rtl/int_req_ctrl.sv | 136 +++++++++++++
 tb/tb_int_req_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_req_ctrl_pkg.sv
// Shared types and constants for the interrupt request controller.
// Optional build macro: INT_REQ_CTRL_ROUND_ROBIN_EN selects round-robin arbitration.
package int_req_ctrl_pkg;

  localparam int unsigned IdWidth  = 3;
  localparam int unsigned VecWidth = 16;
  localparam int unsigned MaxSrc   = 1 << IdWidth;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } state_e;

  // Handler address for a source ID; wraps modulo 2^VecWidth.
  function automatic logic [VecWidth-1:0] calc_vector(input logic [VecWidth-1:0] base,
                                                      input logic [VecWidth-1:0] stride,
                                                      input logic [IdWidth-1:0]  id);
    return base + stride * VecWidth'(id);
  endfunction

endpackage

// File: rtl/int_prio_arb.sv
// Combinational arbiter: fixed lowest-index priority, or round-robin from a start
// pointer when INT_REQ_CTRL_ROUND_ROBIN_EN is defined.
module int_prio_arb
  import int_req_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] eligible,
`ifdef INT_REQ_CTRL_ROUND_ROBIN_EN
  input  logic [IdWidth-1:0] start,
`endif
  output logic               valid,
  output logic [IdWidth-1:0] win_id
);

`ifdef INT_REQ_CTRL_ROUND_ROBIN_EN
  logic [MaxSrc-1:0]  elig_ext;
  logic [IdWidth-1:0] idx;

  assign elig_ext = MaxSrc'(eligible);

  always_comb begin
    valid  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = IdWidth'((32'(start) + k) % NUM_SRC);
      if (!valid && elig_ext[idx]) begin
        valid  = 1'b1;
        win_id = idx;
      end
    end
  end
`else
  always_comb begin
    valid  = 1'b0;
    win_id = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!valid && eligible[i]) begin
        valid  = 1'b1;
        win_id = IdWidth'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/int_req_ctrl.sv
// Interrupt request controller: edge-detect, pending/mask, arbitrate, hold int_flag until ack.
// Optional build macro: INT_REQ_CTRL_ROUND_ROBIN_EN (round-robin arbitration).
module int_req_ctrl
  import int_req_ctrl_pkg::*;
#(
  parameter int unsigned          NUM_SRC     = 4,
  parameter logic [VecWidth-1:0]  VEC_BASE    = 16'h0010,
  parameter logic [VecWidth-1:0]  VEC_STRIDE  = 16'h0002,
  parameter int unsigned          HOLDOFF     = 4,
  parameter int unsigned          ACK_TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  irq_in,
  input  logic [NUM_SRC-1:0]  irq_mask,
  input  logic                ack,
  output logic                int_flag,
  output logic [VecWidth-1:0] vector,
  output logic [IdWidth-1:0]  active_id,
  output logic [NUM_SRC-1:0]  pending,
  output logic                busy,
  output logic                timeout_err
);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_SRC-1:0]  irq_prev_q;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  edges, clr, eligible;
  logic [IdWidth-1:0]  active_id_q, active_id_d;
  logic [VecWidth-1:0] vector_q, vector_d;
  logic                timeout_err_q, timeout_err_d;
  logic                ack_take;
  logic                arb_valid;
  logic [IdWidth-1:0]  arb_id;

  assign edges    = irq_in & ~irq_prev_q;
  assign eligible = pending_q & ~irq_mask;

`ifdef INT_REQ_CTRL_ROUND_ROBIN_EN
  logic [IdWidth-1:0] last_q, last_d, rr_start;

  assign rr_start = (last_q == IdWidth'(NUM_SRC - 1)) ? '0 : last_q + 1'b1;
  // Pointer only moves on a real acknowledge; a timed-out source keeps its turn.
  assign last_d   = ack_take ? active_id_q : last_q;

  always_ff @(posedge clk) begin
    if (reset) last_q <= IdWidth'(NUM_SRC - 1);
    else       last_q <= last_d;
  end
`endif

  int_prio_arb #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .eligible (eligible),
`ifdef INT_REQ_CTRL_ROUND_ROBIN_EN
    .start    (rr_start),
`endif
    .valid    (arb_valid),
    .win_id   (arb_id)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active_id_d   = active_id_q;
    vector_d      = vector_q;
    timeout_err_d = timeout_err_q;
    clr           = '0;
    ack_take      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          active_id_d = arb_id;
          vector_d    = calc_vector(VEC_BASE, VEC_STRIDE, arb_id);
          cnt_d       = '0;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (ack) begin
          clr      = NUM_SRC'(1) << active_id_q;
          ack_take = 1'b1;
          cnt_d    = '0;
          state_d  = StHold;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = StHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == 8'(HOLDOFF - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A fresh edge wins over the acknowledge clear of the same source.
    pending_d = (pending_q & ~clr) | edges;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      irq_prev_q    <= '0;
      pending_q     <= '0;
      active_id_q   <= '0;
      vector_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      irq_prev_q    <= irq_in;
      pending_q     <= pending_d;
      active_id_q   <= active_id_d;
      vector_q      <= vector_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign int_flag    = (state_q == StReq);
  assign busy        = (state_q != StIdle);
  assign vector      = vector_q;
  assign active_id   = active_id_q;
  assign pending     = pending_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_int_req_ctrl.sv
// Randomized and directed bench for int_req_ctrl against a cycle-level behavioural model.
// Honours INT_REQ_CTRL_ROUND_ROBIN_EN in the model's arbitration.
module tb_int_req_ctrl;

  localparam int          NSRC = 4;
  localparam int          HOLD = 4;
  localparam int          TMO  = 32;
  localparam logic [15:0] VB   = 16'h0010;
  localparam logic [15:0] VS   = 16'h0002;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] irq_in;
  logic [NSRC-1:0] irq_mask;
  logic            ack;
  logic            int_flag;
  logic [15:0]     vector;
  logic [2:0]      active_id;
  logic [NSRC-1:0] pending;
  logic            busy;
  logic            timeout_err;

  int_req_ctrl #(
    .NUM_SRC     (NSRC),
    .VEC_BASE    (VB),
    .VEC_STRIDE  (VS),
    .HOLDOFF     (HOLD),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .irq_mask    (irq_mask),
    .ack         (ack),
    .int_flag    (int_flag),
    .vector      (vector),
    .active_id   (active_id),
    .pending     (pending),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: interrupt "up" with an age, then a cooldown, then free to grant.
  bit [NSRC-1:0] m_prev, m_pend;
  bit            m_flag, m_terr;
  int            m_wait, m_gap, m_id, m_last;
  bit [15:0]     m_vec;

  function automatic int pick(input bit [NSRC-1:0] elig, input int start);
    for (int k = 0; k < NSRC; k++) begin
      if (elig[(start + k) % NSRC]) return (start + k) % NSRC;
    end
    return -1;
  endfunction

  task automatic model_edge();
    bit [NSRC-1:0] edges, clr;
    int w;
    if (reset) begin
      m_prev = '0; m_pend = '0; m_flag = 0; m_terr = 0;
      m_wait = 0; m_gap = 0; m_id = 0; m_vec = '0; m_last = NSRC - 1;
    end else begin
      edges  = irq_in & ~m_prev;
      m_prev = irq_in;
      clr    = '0;
      if (m_flag) begin
        m_wait++;
        if (ack) begin
          clr[m_id] = 1'b1; m_flag = 0; m_gap = HOLD; m_last = m_id;
        end else if (m_wait == TMO) begin
          m_flag = 0; m_terr = 1; m_gap = HOLD;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
`ifdef INT_REQ_CTRL_ROUND_ROBIN_EN
        w = pick(m_pend & ~irq_mask, (m_last + 1) % NSRC);
`else
        w = pick(m_pend & ~irq_mask, 0);
`endif
        if (w >= 0) begin
          m_flag = 1; m_wait = 0; m_id = w;
          m_vec  = 16'(VB + VS * 16'(w));
        end
      end
      m_pend = (m_pend & ~clr) | edges;
    end
  endtask

  task automatic compare_all();
    check("int_flag", int_flag, m_flag);
    check("vector", vector, m_vec);
    check("active_id", active_id, m_id);
    check("pending", pending, m_pend);
    check("busy", busy, (m_flag || m_gap > 0));
    check("timeout_err", timeout_err, m_terr);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic do_reset();
    irq_in = '0; irq_mask = '0; ack = 0; reset = 1;
    tick(2);
    reset = 0;
    tick(1);
  endtask

  task automatic pulse_ack();
    ack = 1; tick(1); ack = 0;
  endtask

  task automatic wait_flag(input int budget);
    for (int i = 0; i < budget && !int_flag; i++) tick(1);
  endtask

  int n_hi;

  initial begin
    irq_in = '0; irq_mask = '0; ack = 0; reset = 1;
    tick(1);
    check("reset_flag", int_flag, 0);
    check("reset_pending", pending, 0);
    do_reset();

    // Single request on source 2
    irq_in[2] = 1; tick(1);
    check("s1_pend", pending[2], 1);
    tick(1);
    check("s1_flag", int_flag, 1);
    check("s1_id", active_id, 2);
    check("s1_vec", vector, 16'h0014);
    tick(3);
    pulse_ack();
    check("s1_clr", pending[2], 0);
    check("s1_drop", int_flag, 0);
    tick(3);
    check("s1_busy_hold", busy, 1);
    tick(1);
    check("s1_busy_idle", busy, 0);
    irq_in = '0;

    // Simultaneous edges on 1 and 3
    do_reset();
    irq_in = 4'b1010; tick(2);
    check("s2_id1", active_id, 1);
    check("s2_vec1", vector, 16'h0012);
    pulse_ack();
    wait_flag(20);
    check("s2_flag3", int_flag, 1);
    check("s2_id3", active_id, 3);
    check("s2_vec3", vector, 16'h0016);
    pulse_ack();
    irq_in = '0;

    // Masked source
    do_reset();
    irq_mask = 4'b0001; irq_in[0] = 1; tick(3);
    check("s3_pend", pending[0], 1);
    check("s3_noflag", int_flag, 0);
    irq_mask = '0; tick(2);
    check("s3_flag", int_flag, 1);
    check("s3_id", active_id, 0);
    pulse_ack();
    irq_in = '0;

    // Timeout
    do_reset();
    irq_in[1] = 1;
    wait_flag(10);
    n_hi = 0;
    while (int_flag && n_hi < 100) begin
      n_hi++;
      tick(1);
    end
    check("s4_len", n_hi, TMO);
    check("s4_terr", timeout_err, 1);
    check("s4_pend", pending[1], 1);
    wait_flag(20);
    check("s4_regrant", int_flag, 1);
    check("s4_id", active_id, 1);
    pulse_ack();
    irq_in = '0;

    // Set/clear collision
    do_reset();
    irq_in[2] = 1; tick(2);
    irq_in[2] = 0; tick(2);
    irq_in[2] = 1; ack = 1; tick(1); ack = 0;
    check("s5_pend", pending[2], 1);
    wait_flag(20);
    check("s5_flag", int_flag, 1);
    check("s5_id", active_id, 2);
    pulse_ack();
    irq_in = '0;

    // Reset mid-grant
    do_reset();
    irq_in[3] = 1; tick(2);
    check("s6_flag", int_flag, 1);
    irq_in = '0; reset = 1; tick(1);
    check("s6_rst_flag", int_flag, 0);
    check("s6_rst_pend", pending, 0);
    check("s6_rst_vec", vector, 0);
    check("s6_rst_id", active_id, 0);
    reset = 0; ack = 1; tick(1); ack = 0;
    check("s6_late_ack", busy, 0);

    // Random traffic: frequent acks, then sparse acks to provoke timeouts
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      for (int b = 0; b < NSRC; b++) begin
        if ($urandom_range(5) == 0) irq_in[b] = ~irq_in[b];
      end
      if ($urandom_range(40) == 0) irq_mask = 4'($urandom);
      ack   = (it < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(40) == 0);
      reset = ($urandom_range(400) == 0);
      tick(1);
    end
    reset = 0; ack = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
